// File: rtl/lead_count_pkg.sv
// Shared mode encodings and result-width helper for the leading/trailing count pipe.
package lead_count_pkg;

  localparam logic [1:0] MODE_CLZ = 2'b00;
  localparam logic [1:0] MODE_CLO = 2'b01;
  localparam logic [1:0] MODE_CTZ = 2'b10;
  localparam logic [1:0] MODE_CTO = 2'b11;

  // A count over `width` bits spans 0..width inclusive.
  function automatic int res_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/lead_count_chunk.sv
// Leading-zero count of one CHUNK-bit slice, MSB first; purely combinational.
// count_o = CHUNK and all_o = 1 when the slice is all zeros.
module lead_count_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]       chunk_i,
  output logic [$clog2(CHUNK):0] count_o,
  output logic                   all_o
);

  localparam int CW = $clog2(CHUNK) + 1;

  // Scanning LSB to MSB with last-write-wins leaves the most significant set bit.
  always_comb begin
    count_o = CW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk_i[i]) count_o = CW'(CHUNK - 1 - i);
    end
  end

  assign all_o = ~|chunk_i;

endmodule

// File: rtl/lead_count_pipe.sv
// Two-stage CLZ/CLO pipe with valid/ready, flush and tag pass-through; result 2 cycles after accept.
// Optional LEAD_COUNT_TRAILING_EN adds CTZ/CTO by bit-reversing the operand ahead of stage 1.
module lead_count_pipe
  import lead_count_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [1:0]                    in_mode,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [res_width(WIDTH)-1:0]   out_count,
  output logic                          out_all,
  output logic [TAG_W-1:0]              out_tag
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CW    = res_width(CHUNK);
  localparam int RES_W = res_width(WIDTH);

  logic [WIDTH-1:0]         opnd;
  logic [NCH-1:0][CW-1:0]   s1_cnt_d, s1_cnt_q;
  logic [NCH-1:0]           s1_all_d, s1_all_q;
  logic [TAG_W-1:0]         s1_tag_q;
  logic                     s1_vld_q;
  logic [RES_W-1:0]         out_cnt_d, out_cnt_q;
  logic                     out_all_d, out_all_q;
  logic [TAG_W-1:0]         out_tag_q;
  logic                     out_vld_q;
  logic                     s2_adv, in_xfer;

  always_comb begin
    opnd = in_data;
`ifdef LEAD_COUNT_TRAILING_EN
    if (in_mode[1]) begin
      for (int i = 0; i < WIDTH; i++) opnd[i] = in_data[WIDTH-1-i];
    end
`endif
    if (in_mode[0]) opnd = ~opnd;
  end

`ifndef LEAD_COUNT_TRAILING_EN
  logic unused_mode_hi;
  assign unused_mode_hi = in_mode[1];
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    lead_count_chunk #(.CHUNK(CHUNK)) u_chunk (
      .chunk_i (opnd[g*CHUNK +: CHUNK]),
      .count_o (s1_cnt_d[g]),
      .all_o   (s1_all_d[g])
    );
  end

  // Ready chains straight back from the consumer; there is no skid slot.
  assign s2_adv   = !out_vld_q || out_ready;
  assign in_ready = !rst && !flush && (!s1_vld_q || s2_adv);
  assign in_xfer  = in_valid && in_ready;

  // Chunk NCH-1 holds the MSBs; the highest chunk that is not all-zero decides the count.
  always_comb begin
    out_cnt_d = RES_W'(WIDTH);
    out_all_d = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (!s1_all_q[i]) begin
        out_cnt_d = RES_W'((NCH - 1 - i) * CHUNK) + RES_W'(s1_cnt_q[i]);
        out_all_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (flush) begin
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      if (s2_adv)   out_vld_q <= s1_vld_q;
      if (in_ready) s1_vld_q  <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_cnt_q <= s1_cnt_d;
      s1_all_q <= s1_all_d;
      s1_tag_q <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_q <= '0;
      out_all_q <= 1'b0;
      out_tag_q <= '0;
    end else if (!flush && s1_vld_q && s2_adv) begin
      out_cnt_q <= out_cnt_d;
      out_all_q <= out_all_d;
      out_tag_q <= s1_tag_q;
    end
  end

  assign out_valid = out_vld_q;
  assign out_count = out_cnt_q;
  assign out_all   = out_all_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_lead_count_pipe.sv
// Directed bench for lead_count_pipe: a 32/8 instance and a 64/16 instance share one clock.
module tb_lead_count_pipe;
  import lead_count_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_all;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [5:0]  out_count;

  logic        w_rst, w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_all;
  logic [63:0] w_in_data;
  logic [1:0]  w_in_mode;
  logic [4:0]  w_in_tag, w_out_tag;
  logic [6:0]  w_out_count;

  lead_count_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_all(out_all), .out_tag(out_tag)
  );

  lead_count_pipe #(.WIDTH(64), .CHUNK(16), .TAG_W(5)) dut_w (
    .clk(clk), .rst(w_rst), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_mode(w_in_mode), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_count(w_out_count), .out_all(w_out_all), .out_tag(w_out_tag)
  );

  task automatic test_reset();
    rst = 1'b1; w_rst = 1'b1; in_valid = 1'b1; in_data = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    end
    vectors++; if (out_count !== 6'd0 || out_all !== 1'b0 || out_tag !== 5'd0) begin
      miscompares++; $display("FAIL reset_out_regs: got count=%0d all=%b tag=%0d expected 0/0/0", out_count, out_all, out_tag);
    end
    vectors++; if (w_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wide_valid: got %b expected 0", w_out_valid); end
    @(posedge clk); #1;
    rst = 1'b0; w_rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_mode_sweep();
    logic [31:0] d [9];
    logic [1:0]  m [9];
    logic [5:0]  ec [9];
    logic        ea [9];
    d  = '{32'h8000_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000,
           32'hFFFF_FFFF, 32'hF000_0000, 32'h7FFF_FFFF, 32'h0000_0100, 32'h0000_00FF};
    m  = '{MODE_CLZ, MODE_CLZ, MODE_CLZ, MODE_CLZ, MODE_CLO, MODE_CLO, MODE_CLO, MODE_CTZ, MODE_CTO};
    ec = '{6'd0, 6'd15, 6'd31, 6'd32, 6'd32, 6'd4, 6'd0, 6'd23, 6'd0};
    ea = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef LEAD_COUNT_TRAILING_EN
    ec[7] = 6'd8;
    ec[8] = 6'd8;
`endif
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 9);
      if (c < 9) begin in_data = d[c]; in_mode = m[c]; in_tag = 5'(c + 10); end
      @(negedge clk);
      if (c < 9) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL sweep_in_ready[%0d]: got %b expected 1", c, in_ready); end
      end
      if (c >= 2 && c < 11) begin
        vectors++;
        if (out_valid !== 1'b1 || out_count !== ec[c-2] || out_all !== ea[c-2] || out_tag !== 5'(c + 8)) begin
          miscompares++;
          $display("FAIL sweep_result[%0d]: got v=%b count=%0d all=%b tag=%0d expected v=1 count=%0d all=%b tag=%0d",
                   c - 2, out_valid, out_count, out_all, out_tag, ec[c-2], ea[c-2], c + 8);
        end
      end else begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sweep_idle[%0d]: got out_valid=%b expected 0", c, out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [4];
    logic [5:0]  ec [4];
    logic [5:0]  hold_cnt;
    logic        hold_all, stalled;
    logic [4:0]  hold_tag;
    int sent, recv, c;
    vals = '{32'h0000_F000, 32'h0800_0000, 32'h0000_0003, 32'h4000_0000};
    ec   = '{6'd16, 6'd4, 6'd30, 6'd1};
    sent = 0; recv = 0; c = 0; stalled = 1'b0;
    hold_cnt = '0; hold_all = 1'b0; hold_tag = '0;
    while (recv < 4 && c < 40) begin
      @(posedge clk); #1;
      in_valid = (sent < 4);
      if (sent < 4) begin in_data = vals[sent]; in_mode = MODE_CLZ; in_tag = 5'(sent + 1); end
      out_ready = !(c >= 2 && c <= 4);
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_drop[%0d]: got %b expected 0", c, in_ready); end
      end
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_count !== hold_cnt || out_all !== hold_all || out_tag !== hold_tag) begin
          miscompares++;
          $display("FAIL bp_hold[%0d]: got v=%b count=%0d tag=%0d expected v=1 count=%0d tag=%0d",
                   c, out_valid, out_count, out_tag, hold_cnt, hold_tag);
        end
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      if (stalled) begin hold_cnt = out_count; hold_all = out_all; hold_tag = out_tag; end
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (out_count !== ec[recv] || out_all !== 1'b0 || out_tag !== 5'(recv + 1)) begin
          miscompares++;
          $display("FAIL bp_order[%0d]: got count=%0d all=%b tag=%0d expected count=%0d all=0 tag=%0d",
                   recv, out_count, out_all, out_tag, ec[recv], recv + 1);
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      c++;
    end
    vectors++; if (recv != 4) begin miscompares++; $display("FAIL bp_timeout: got %0d results expected 4", recv); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h0000_0F00; in_mode = MODE_CLZ; in_tag = 5'd5;
    @(posedge clk); #1;
    in_data = 32'h0000_0001; in_tag = 5'd6;
    @(posedge clk); #1;
    flush = 1'b1; in_data = 32'h0000_0001; in_tag = 5'd7;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    vectors++; if (out_valid !== 1'b1 || out_count !== 6'd20 || out_tag !== 5'd5) begin
      miscompares++; $display("FAIL flush_cycle_out: got v=%b count=%0d tag=%0d expected v=1 count=20 tag=5", out_valid, out_count, out_tag);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drop[%0d]: got out_valid=%b expected 0", c, out_valid); end
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = 32'h0000_0010; in_tag = 5'd9;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_resume_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_resume_early: got out_valid=%b expected 0", out_valid); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1 || out_count !== 6'd27 || out_all !== 1'b0 || out_tag !== 5'd9) begin
      miscompares++; $display("FAIL flush_resume_result: got v=%b count=%0d tag=%0d expected v=1 count=27 tag=9", out_valid, out_count, out_tag);
    end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_resume_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_midstall();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h0000_0080; in_mode = MODE_CLZ; in_tag = 5'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1 || out_count !== 6'd24 || out_tag !== 5'd3) begin
      miscompares++; $display("FAIL midstall_held: got v=%b count=%0d tag=%0d expected v=1 count=24 tag=3", out_valid, out_count, out_tag);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midstall_rst_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0 || out_count !== 6'd0 || out_tag !== 5'd0) begin
      miscompares++; $display("FAIL midstall_discard: got v=%b count=%0d tag=%0d expected 0/0/0", out_valid, out_count, out_tag);
    end
  endtask

  task automatic test_wide();
    logic [63:0] d [4];
    logic [1:0]  m [4];
    logic [6:0]  ec [4];
    logic        ea [4];
    int n;
    d  = '{64'h0000_0000_0010_0000, 64'h0, 64'hFFFF_0000_0000_0000, 64'h0000_0000_0010_0000};
    m  = '{MODE_CLZ, MODE_CLZ, MODE_CLO, MODE_CTZ};
    ec = '{7'd43, 7'd64, 7'd16, 7'd20};
    ea = '{1'b0, 1'b1, 1'b0, 1'b0};
`ifdef LEAD_COUNT_TRAILING_EN
    n = 4;
`else
    n = 3;
`endif
    for (int c = 0; c < n + 3; c++) begin
      @(posedge clk); #1;
      w_in_valid = (c < n);
      if (c < n) begin w_in_data = d[c]; w_in_mode = m[c]; w_in_tag = 5'(c + 20); end
      @(negedge clk);
      if (c >= 2 && c < n + 2) begin
        vectors++;
        if (w_out_valid !== 1'b1 || w_out_count !== ec[c-2] || w_out_all !== ea[c-2] || w_out_tag !== 5'(c + 18)) begin
          miscompares++;
          $display("FAIL wide_result[%0d]: got v=%b count=%0d all=%b tag=%0d expected v=1 count=%0d all=%b tag=%0d",
                   c - 2, w_out_valid, w_out_count, w_out_all, w_out_tag, ec[c-2], ea[c-2], c + 18);
        end
      end else begin
        vectors++; if (w_out_valid !== 1'b0) begin miscompares++; $display("FAIL wide_idle[%0d]: got out_valid=%b expected 0", c, w_out_valid); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = MODE_CLZ; in_tag = '0; out_ready = 1'b1;
    w_rst = 1'b1; w_flush = 1'b0; w_in_valid = 1'b0; w_in_data = '0; w_in_mode = MODE_CLZ; w_in_tag = '0; w_out_ready = 1'b1;
    test_reset();
    test_mode_sweep();
    test_backpressure();
    test_flush();
    test_reset_midstall();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lead_count_pipe.md
Name: lead_count_pipe

Overview:
- Parametrised, two-stage pipelined leading-zero/leading-one counter for the CPU's CLZ/CLO execute path.
- Generalises the 32-bit combinational priority encoder in three ways:
  - operand width is configurable;
  - it adds a mode selecting zeros or ones;
  - it adds a valid/ready handshake with backpressure, a flush, and a destination-tag pass-through.
- Sits beside the ALU; the tag carries the destination register number to writeback.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- CHUNK, 8, bits per stage-1 chunk; power of two, divides WIDTH, 2..WIDTH.
- TAG_W, 5, width of the pass-through tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  drop all in-flight entries.
- in_valid  in  1  operand present.
- in_ready  out  1  block accepts this cycle.
- in_data  in  WIDTH  operand.
- in_mode  in  2  bit0: 0=count leading zeros, 1=count leading ones; bit1 is reserved (see Optional Feature).
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_count  out  RES_W  count, where RES_W = $clog2(WIDTH)+1.
- out_all  out  1  operand was entirely the counted value.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Counted value:
  - CLZ counts from the MSB downward until the first 1.
  - CLO inverts the operand first, then applies the same count.
- Result range: 0..WIDTH.
  - Operand all counted-value: out_count=WIDTH and out_all=1; otherwise out_all=0.
  - Example: WIDTH=32, CLZ of 0 gives 32.
- Stage 1 (S1) registers, per chunk: the chunk's leading count (width $clog2(CHUNK)+1) and an all-flag, plus the tag and mode.
- Stage 2 (S2) finds the first chunk (from the MSB) whose all-flag is 0. It then computes count = index*CHUNK + chunk_count and registers the result on the outputs.
- Latency and throughput:
  - Accept in cycle N gives out_valid in cycle N+2 when there is no stall.
  - Throughput is 1 per cycle.
- Stall rules:
  - S2 holds while out_valid && !out_ready.
  - S1 advances when S2 is empty or S2 is transferring.
  - in_ready = !flush && (!S1_valid || S1_advances).
  - This is a combinational ready chain; no skid buffer.
- Output stability: while out_valid && !out_ready, out_count, out_all and out_tag hold stable.
- Flush:
  - flush=1 clears both stage valids at the next edge.
  - in_ready=0 during flush, so a simultaneous in_valid is not accepted.
  - out_valid may be 1 in the flush cycle. An output transfer in that cycle counts; after the edge, out_valid=0.
- Reset:
  - rst=1 at an edge clears the S1 and S2 valids, out_count=0, out_all=0 and out_tag=0.
  - in_ready=0 while rst=1.
  - rst overrides flush and all transfers; a reset mid-stall discards the held result.
- Mode decoding: when the macro is absent, in_mode[1] is ignored and treated as 0.
- Unknowns: no X propagates from the data path when in_valid=0; data registers load only on an input transfer.

Optional Feature:
- Macro LEAD_COUNT_TRAILING_EN.
- When defined:
  - in_mode[1]=1 selects trailing counts: the operand is bit-reversed before the invert and the chunk stage.
  - This gives CTZ (mode 2'b10) and CTO (mode 2'b11) with identical latency.
  - Example: CTZ of 32'h0000_0100 = 8.
- When undefined: in_mode[1] is ignored, and there is no reversal logic or mux.

Decomposition:
- Package lead_count_pkg holds:
  - mode encodings MODE_CLZ=2'b00, MODE_CLO=2'b01, MODE_CTZ=2'b10, MODE_CTO=2'b11;
  - a res_width(width) function returning $clog2(width)+1.
- One combinational sub-module, lead_count_chunk (parameter CHUNK), is natural.
  - Inputs: CHUNK bits.
  - Outputs: the count and the all-flag.
  - Instantiated WIDTH/CHUNK times in S1.
- The top level owns the handshake, flush and pipeline registers.

Test Plan:
- Reset then idle: rst high 2 cycles → out_valid=0, in_ready=0 during rst, in_ready=1 one cycle after release.
- Mode sweep, CLZ: feed 32'h8000_0000, 32'h0001_0000, 32'h0000_0001, 32'h0 back-to-back → out_count 0, 15, 31, 32 with out_all=1 only on the last, each 2 cycles after accept, one per cycle.
- Mode sweep, CLO: feed 32'hFFFF_FFFF, 32'hF000_0000, 32'h7FFF_FFFF → 32 (all=1), 4, 0.
- Backpressure: stream 4 operands with tags 1..4 and out_ready low 3 cycles mid-stream → in_ready drops once S1 and S2 are full; outputs hold stable; tags emerge 1,2,3,4 with none lost or duplicated.
- Flush: 2 entries in flight plus in_valid=1 with flush=1 → out_valid=0 next cycle, the offered operand is not accepted, and the next operand after flush returns its result normally.
- Width/feature variant: WIDTH=64, CHUNK=16 with LEAD_COUNT_TRAILING_EN, CTZ of 64'h0000_0000_0010_0000 → 20; CLZ of the same → 43; CLZ of 0 → 64 with out_all=1.
